// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state type and depth helper for the capture sequencer
package capture_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;

  // Sample RAM depth for a given address width
  function automatic int smpl_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/wrap_addr_cnt.sv
// rtl/wrap_addr_cnt.sv - circular RAM write-address counter with sync clear
module wrap_addr_cnt #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  // Clear wins over increment; binary overflow provides the D-1 -> 0 wrap
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture sequencer: pre-trigger fill, arm, post-trigger count, hold
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              en_sample,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              ack,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic              busy
);

  // One extra bit so the pre-trigger threshold can reach D when tpos_q is 0
  localparam logic [ADDR_W:0] SMPL_DEPTH = (ADDR_W+1)'(smpl_depth(ADDR_W));

  cap_state_t        state;
  cap_state_t        state_n;
  logic [ADDR_W-1:0] tpos_q;
  logic [ADDR_W:0]   smpl_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   smpl_nxt;
  logic [ADDR_W-1:0] post_nxt;
  logic [ADDR_W:0]   pre_thresh;
  logic              trig_acc;

  assign smpl_nxt   = smpl_cnt + (ADDR_W+1)'(1);
  assign post_nxt   = post_cnt + ADDR_W'(1);
  assign pre_thresh = SMPL_DEPTH - {1'b0, tpos_q};
  assign trig_acc   = (state == ARMED) && trig_in;

  wrap_addr_cnt #(.ADDR_W(ADDR_W)) u_waddr (
    .clk   (clk),
    .clr   (rst),
    .inc   (we),
    .count (waddr)
  );

  // State register; status outputs are registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      armed        <= (state_n == ARMED);
      capture_done <= (state_n == DONE);
      busy         <= (state_n != IDLE);
    end
  end

  // Next-state: threshold and final writes are detected on the write that reaches them
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = PRE;
      PRE:     if (we && (smpl_nxt == pre_thresh)) state_n = ARMED;
      ARMED:   if (trig_in) state_n = (tpos_q == '0) ? DONE : POST;
      POST:    if (we && (post_nxt == tpos_q)) state_n = DONE;
      DONE:    if (ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // RAM write strobe is the only combinational output
  always_comb begin
    we = 1'b0;
    if ((state == PRE) || (state == ARMED) || (state == POST)) begin
      we = en_sample;
    end
  end

  // Pre/post sample counters and the latched post-trigger length
  always_ff @(posedge clk) begin
    if (rst) begin
      tpos_q   <= '0;
      smpl_cnt <= '0;
      post_cnt <= '0;
    end else if ((state == IDLE) && run) begin
      tpos_q   <= trig_pos;
      smpl_cnt <= '0;
      post_cnt <= '0;
    end else if ((state == PRE) && we) begin
      smpl_cnt <= smpl_nxt;
    end else if ((state == POST) && we) begin
      post_cnt <= post_nxt;
    end
  end

  // Trigger address points at the next sample slot; a same-cycle write counts as pre-trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_addr <= '0;
    end else if (trig_acc) begin
      trig_addr <= waddr + ADDR_W'(we);
    end else if (state_n == IDLE) begin
      trig_addr <= '0;
    end
  end

endmodule
